instr_mem_prog: RTL and testbench

Parametrised byte-addressed instruction memory with a serial byte-loader port. A host streams the program in through a valid/ready handshake before the core runs. A load FSM tracks the programmed extent. Every fetch outside that extent, misaligned, or made while not running returns a HALT sentinel, and the core is held while loading.

---
 rtl/instr_mem_prog.sv | 149 ++++++++++++++
 tb/tb_instr_mem_prog.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_prog.sv
// instr_mem_prog: byte-addressed instruction memory loaded serially by a host.
//
// A host streams the program one byte at a time over a valid/ready handshake.
// Once the final byte arrives, or the memory fills, the block enters RUN and
// releases the core. Fetches are combinational, little-endian 32-bit words.
// Any fetch outside the loaded extent, misaligned, or made outside RUN
// returns HALT_WORD.
//
// Ports:
//   CLK, RST                         clock (rising edge), async active-low reset
//   Load_Start                       request to (re)enter LOAD
//   Load_Valid/Load_Data/Load_Last   byte stream in, ascending addresses
//   Load_Ready                       loader accepts a byte (high only in LOAD)
//   Load_Count                       bytes accepted in the current or last load
//   Load_Done                        high in RUN
//   Overflow_Err                     sticky: memory filled without Load_Last
//   CPU_Hold                         core stall, high unless in RUN
//   Read_Address                     fetch byte address
//   Instruction                      fetched word (combinational)
//   Misaligned                       Read_Address[1:0] != 0
module instr_mem_prog #(
  parameter int unsigned            INST_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 8,
  parameter logic [INST_WIDTH-1:0]  HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Load_Start,
  input  logic                  Load_Valid,
  input  logic [7:0]            Load_Data,
  input  logic                  Load_Last,
  output logic                  Load_Ready,
  output logic [ADDR_WIDTH:0]   Load_Count,
  output logic                  Load_Done,
  output logic                  Overflow_Err,
  output logic                  CPU_Hold,
  input  logic [INST_WIDTH-1:0] Read_Address,
  output logic [INST_WIDTH-1:0] Instruction,
  output logic                  Misaligned
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Count value once every byte of the memory has been written.
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [1:0]            r_state;
  // The write pointer and the accepted-byte count always move together, so a
  // single register serves as both.
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_prog_end;
  logic                  r_overflow;
  logic [7:0]            r_mem [Depth];

  logic                  w_handshake;
  logic [ADDR_WIDTH:0]   w_count_inc;

  assign w_handshake = Load_Valid && (r_state == ST_LOAD);
  assign w_count_inc = r_count + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_prog_end <= '0;
      r_overflow <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (Load_Start) begin
            r_state <= ST_LOAD;
            r_count <= '0;
          end
        end
        ST_LOAD: begin
          if (w_handshake) begin
            r_count <= w_count_inc;
            if (Load_Last) begin
              r_prog_end <= w_count_inc;
              r_state    <= ST_RUN;
            end else if (w_count_inc == FULL_COUNT) begin
              r_prog_end <= FULL_COUNT;
              r_overflow <= 1'b1;
              r_state    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (Load_Start) begin
            r_state    <= ST_LOAD;
            r_count    <= '0;
            r_prog_end <= '0;
            r_overflow <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory is deliberately not reset; Prog_End gates every read.
  always_ff @(posedge CLK) begin
    if (w_handshake) begin
      r_mem[r_count[ADDR_WIDTH-1:0]] <= Load_Data;
    end
  end

  assign Load_Ready   = (r_state == ST_LOAD);
  assign Load_Done    = (r_state == ST_RUN);
  assign CPU_Hold     = (r_state != ST_RUN);
  assign Load_Count   = r_count;
  assign Overflow_Err = r_overflow;

  // Fetch path
  logic [ADDR_WIDTH-1:0] w_a0;
  logic [ADDR_WIDTH-1:0] w_a1;
  logic [ADDR_WIDTH-1:0] w_a2;
  logic [ADDR_WIDTH-1:0] w_a3;
  logic [ADDR_WIDTH:0]   w_last_byte;
  logic                  w_out_of_range;
  logic                  w_past_end;
  logic [31:0]           w_word;

  assign w_a0 = Read_Address[ADDR_WIDTH-1:0];
  assign w_a1 = w_a0 + ADDR_WIDTH'(1);
  assign w_a2 = w_a0 + ADDR_WIDTH'(2);
  assign w_a3 = w_a0 + ADDR_WIDTH'(3);

  // Widened by one bit so a word straddling the top of memory cannot wrap
  // back into the valid range.
  assign w_last_byte    = {1'b0, w_a0} + (ADDR_WIDTH + 1)'(3);
  assign w_past_end     = (w_last_byte >= r_prog_end);
  assign w_out_of_range = |Read_Address[INST_WIDTH-1:ADDR_WIDTH];
  assign Misaligned     = |Read_Address[1:0];

  assign w_word = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[w_a0]};

  always_comb begin
    Instruction = w_word;
    if ((r_state != ST_RUN) || Misaligned || w_out_of_range || w_past_end) begin
      Instruction = HALT_WORD;
    end
  end

endmodule

// File: tb/tb_instr_mem_prog.sv
module tb_instr_mem_prog;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        start;
  logic        valid;
  logic [7:0]  data;
  logic        last;
  logic [31:0] raddr;

  // Instance 0: ADDR_WIDTH = 8, instance 1: ADDR_WIDTH = 4 (shared stimulus).
  logic        rdy8, done8, ovf8, hold8, mis8;
  logic [8:0]  cnt8;
  logic [31:0] ins8;
  logic        rdy4, done4, ovf4, hold4, mis4;
  logic [4:0]  cnt4;
  logic [31:0] ins4;

  instr_mem_prog #(.INST_WIDTH(32), .ADDR_WIDTH(8), .HALT_WORD(HALT)) u_dut8 (
    .CLK(clk), .RST(rst), .Load_Start(start), .Load_Valid(valid), .Load_Data(data),
    .Load_Last(last), .Load_Ready(rdy8), .Load_Count(cnt8), .Load_Done(done8),
    .Overflow_Err(ovf8), .CPU_Hold(hold8), .Read_Address(raddr), .Instruction(ins8),
    .Misaligned(mis8)
  );

  instr_mem_prog #(.INST_WIDTH(32), .ADDR_WIDTH(4), .HALT_WORD(HALT)) u_dut4 (
    .CLK(clk), .RST(rst), .Load_Start(start), .Load_Valid(valid), .Load_Data(data),
    .Load_Last(last), .Load_Ready(rdy4), .Load_Count(cnt4), .Load_Done(done4),
    .Overflow_Err(ovf4), .CPU_Hold(hold4), .Read_Address(raddr), .Instruction(ins4),
    .Misaligned(mis4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 loading, 2 running.
  int          m_phase [2];
  int          m_cnt   [2];
  int          m_end   [2];
  logic        m_ovf   [2];
  logic [7:0]  m_mem   [2][256];
  int          m_depth [2] = '{256, 16};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = 0; m_cnt[i] = 0; m_end[i] = 0; m_ovf[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_phase[i] == 0) begin
          if (start) begin m_phase[i] = 1; m_cnt[i] = 0; end
        end else if (m_phase[i] == 1) begin
          if (valid) begin
            m_mem[i][m_cnt[i]] = data;
            m_cnt[i]++;
            if (last) begin
              m_end[i] = m_cnt[i]; m_phase[i] = 2;
            end else if (m_cnt[i] == m_depth[i]) begin
              m_end[i] = m_depth[i]; m_ovf[i] = 1'b1; m_phase[i] = 2;
            end
          end
        end else if (start) begin
          m_phase[i] = 1; m_cnt[i] = 0; m_end[i] = 0; m_ovf[i] = 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] m_fetch(input int i, input logic [31:0] a);
    if (m_phase[i] != 2 || (a % 4) != 0 || a >= 32'(m_depth[i]) || a + 3 >= 32'(m_end[i]))
      return HALT;
    return {m_mem[i][a+3], m_mem[i][a+2], m_mem[i][a+1], m_mem[i][a]};
  endfunction

  task automatic cmp_inst(input int i, input logic rdy, input logic [31:0] cnt,
                          input logic done, input logic ovf, input logic hold,
                          input logic [31:0] ins, input logic mis);
    check($sformatf("ready[%0d]", i), {31'd0, rdy}, {31'd0, m_phase[i] == 1});
    check($sformatf("count[%0d]", i), cnt, 32'(m_cnt[i]));
    check($sformatf("done[%0d]", i), {31'd0, done}, {31'd0, m_phase[i] == 2});
    check($sformatf("ovf[%0d]", i), {31'd0, ovf}, {31'd0, m_ovf[i]});
    check($sformatf("hold[%0d]", i), {31'd0, hold}, {31'd0, m_phase[i] != 2});
    check($sformatf("instr[%0d]", i), ins, m_fetch(i, raddr));
    check($sformatf("misaligned[%0d]", i), {31'd0, mis}, {31'd0, raddr[1:0] != 2'b00});
  endtask

  // Inputs change 2 time units after a rising edge; compare on falling edges.
  initial begin
    forever begin
      @(negedge clk);
      cmp_inst(0, rdy8, 32'(cnt8), done8, ovf8, hold8, ins8, mis8);
      cmp_inst(1, rdy4, 32'(cnt4), done4, ovf4, hold4, ins4, mis4);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    valid = 1'b1; data = b; last = l;
    cyc();
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic fetch2(input string name, input logic [31:0] a,
                        input logic [31:0] exp8, input logic [31:0] exp4);
    raddr = a;
    #1;
    check({name, "/aw8"}, ins8, exp8);
    check({name, "/aw4"}, ins4, exp4);
  endtask

  logic [7:0] prog1 [8] = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] prog6 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    rst = 1'b0; start = 1'b0; valid = 1'b0; data = '0; last = 1'b0; raddr = '0;
    repeat (3) cyc();
    check("reset ready", {31'd0, rdy8}, 32'd0);
    check("reset hold", {31'd0, hold8}, 32'd1);
    check("reset count", 32'(cnt8), 32'd0);
    check("reset ovf", {31'd0, ovf4}, 32'd0);
    rst = 1'b1;
    cyc();

    // Two-instruction program, Last on byte 8.
    pulse_start();
    check("load ready", {31'd0, rdy8}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) check("hold before last", {31'd0, hold8}, 32'd1);
      send(prog1[k], k == 7);
    end
    check("hold after last", {31'd0, hold8}, 32'd0);
    check("count 8", 32'(cnt8), 32'd8);
    fetch2("t1 fetch0", 32'd0, 32'h2008_0013, 32'h2008_0013);
    fetch2("t1 fetch4", 32'd4, 32'h0010_0093, 32'h0010_0093);
    fetch2("t1 fetch8", 32'd8, HALT, HALT);

    // Six bytes: partial final word and misaligned fetch halt.
    pulse_start();
    for (int k = 0; k < 6; k++) send(8'(8'h11 * (k + 1)), k == 5);
    fetch2("t2 fetch0", 32'd0, 32'h4433_2211, 32'h4433_2211);
    fetch2("t2 fetch4", 32'd4, HALT, HALT);
    fetch2("t2 fetch2", 32'd2, HALT, HALT);
    check("t2 misaligned", {31'd0, mis8}, 32'd1);

    // Out-of-range fetch; Load_Valid in RUN is ignored.
    fetch2("t3 fetch100", 32'h100, HALT, HALT);
    fetch2("t3 fetch10", 32'h10, HALT, HALT);
    for (int k = 0; k < 3; k++) send(8'h5A, 1'b0);
    check("t3 count run", 32'(cnt8), 32'd6);
    fetch2("t3 refetch0", 32'd0, 32'h4433_2211, 32'h4433_2211);

    // 16 bytes, no Last: the small instance overflows.
    pulse_start();
    for (int k = 0; k < 16; k++) send(8'(8'hA0 + k), 1'b0);
    check("t4 ovf aw4", {31'd0, ovf4}, 32'd1);
    check("t4 done aw4", {31'd0, done4}, 32'd1);
    check("t4 ovf aw8", {31'd0, ovf8}, 32'd0);
    check("t4 count aw8", 32'(cnt8), 32'd16);
    fetch2("t4 fetch12", 32'd12, HALT, 32'hAFAE_ADAC);
    send(8'hEE, 1'b1);
    check("t4 count aw4 held", 32'(cnt4), 32'd16);

    // Reload clears overflow; stale bytes beyond the new program stay hidden.
    pulse_start();
    check("t6 ovf cleared", {31'd0, ovf4}, 32'd0);
    for (int k = 0; k < 4; k++) send(prog6[k], k == 3);
    fetch2("t6 fetch0", 32'd0, 32'hDDCC_BBAA, 32'hDDCC_BBAA);
    fetch2("t6 fetch4", 32'd4, HALT, HALT);

    // Full memory with Last on the final byte: no overflow.
    pulse_start();
    for (int k = 0; k < 16; k++) send(8'(8'hA0 + k), k == 15);
    check("t4b ovf aw4", {31'd0, ovf4}, 32'd0);
    check("t4b count aw4", 32'(cnt4), 32'd16);
    fetch2("t4b fetch12", 32'd12, 32'hAFAE_ADAC, 32'hAFAE_ADAC);

    // Reset in the middle of a load.
    pulse_start();
    for (int k = 0; k < 3; k++) send(8'h77, 1'b0);
    rst = 1'b0;
    #1;
    check("t5 count", 32'(cnt8), 32'd0);
    check("t5 ready", {31'd0, rdy8}, 32'd0);
    check("t5 hold", {31'd0, hold4}, 32'd1);
    cyc();
    rst = 1'b1;
    fetch2("t5 fetch0 idle", 32'd0, HALT, HALT);
    for (int k = 0; k < 3; k++) send(8'h33, 1'b1);
    check("t5 idle count", 32'(cnt8), 32'd0);
    fetch2("t5 fetch0 still idle", 32'd0, HALT, HALT);
    pulse_start();
    for (int k = 0; k < 4; k++) send(8'(k + 1), k == 3);
    fetch2("t5 reload fetch0", 32'd0, 32'h0403_0201, 32'h0403_0201);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
